// File: rtl/hms_timekeeper.sv
// Time-of-day clock plus shared stopwatch/countdown counter, all advanced by a
// single-clock sub-second enable, with registered packed-BCD display outputs.
module hms_timekeeper #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SUBSEC   = 100,
  parameter int HOUR_MAX = 24,
  parameter int ALARM_S  = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       run,
  input  logic       clear,
  input  logic       load,
  input  logic [4:0] load_h,
  input  logic [5:0] load_m,
  input  logic [5:0] load_s,
  output logic [7:0] h_bcd,
  output logic [7:0] m_bcd,
  output logic [7:0] s_bcd,
  output logic [7:0] ss_bcd,
  output logic       tick_1s,
  output logic       hour_pulse,
  output logic       done,
  output logic       alarm,
  output logic       running,
  output logic       sat,
  output logic       load_err
);

  localparam int PRE = CLK_HZ / SUBSEC;
  localparam int PW  = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int AW  = (ALARM_S > 1) ? $clog2(ALARM_S) : 1;
  localparam logic [1:0] MODE_CLK = 2'b00;
  localparam logic [1:0] MODE_SW  = 2'b01;
  localparam logic [1:0] MODE_TMR = 2'b10;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE - 1);
  localparam logic [AW-1:0] ALM_LAST = AW'(ALARM_S - 1);
  localparam logic [6:0] SS_MAX = 7'(SUBSEC - 1);
  localparam logic [4:0] H_MAX  = 5'(HOUR_MAX - 1);

  // Values are at most 99, so nine compare/subtract steps cover the tens digit.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] rem;
    logic [3:0] tens;
    rem  = v;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end else begin
        rem  = rem;
      end
    end
    return {tens, 4'd0} | {1'b0, rem};
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0] c_h_q, c_h_d, f_h_q, f_h_d, inc_h, dec_h;
  logic [5:0] c_m_q, c_m_d, f_m_q, f_m_d, inc_m, dec_m;
  logic [5:0] c_s_q, c_s_d, f_s_q, f_s_d, inc_s, dec_s;
  logic [6:0] c_ss_q, c_ss_d, f_ss_q, f_ss_d, inc_ss, dec_ss;
  logic sat_q, sat_d, alarm_q, alarm_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic tick_q, hour_q, done_q;

  logic load_ok_s, clk_ld_s, tmr_ld_s, ld_err_s;
  logic sub_tick_s, sec_tick_s, hour_s, done_s;
  logic f_zero_s, f_max_s, inc_max_s, dec_zero_s;
  logic sw_cnt_s, tm_cnt_s, running_s;
  logic [4:0] disp_h_s;
  logic [5:0] disp_m_s, disp_s_s;
  logic [6:0] disp_ss_s;

  // Load qualification, tick generation and counting enables; clear outranks load.
  always_comb begin
    load_ok_s  = (load_h < 5'(HOUR_MAX)) && (load_m <= 6'd59) && (load_s <= 6'd59);
    clk_ld_s   = load && !clear && (mode == MODE_CLK) && load_ok_s;
    tmr_ld_s   = load && !clear && (mode == MODE_TMR) && load_ok_s;
    ld_err_s   = load && !clear && ((mode == MODE_CLK) || (mode == MODE_TMR)) && !load_ok_s;
    sub_tick_s = (presc_q == PRE_LAST);
    sec_tick_s = sub_tick_s && (c_ss_q == SS_MAX) && !clk_ld_s;
    hour_s     = sec_tick_s && (c_m_q == 6'd59) && (c_s_q == 6'd59);
    f_zero_s   = (f_h_q == 5'd0) && (f_m_q == 6'd0) && (f_s_q == 6'd0) && (f_ss_q == 7'd0);
    f_max_s    = (f_h_q == H_MAX) && (f_m_q == 6'd59) && (f_s_q == 6'd59) && (f_ss_q == SS_MAX);
    sw_cnt_s   = (mode == MODE_SW) && run && sub_tick_s && !sat_q && !clear;
    tm_cnt_s   = (mode == MODE_TMR) && run && sub_tick_s && !f_zero_s && !tmr_ld_s;
    running_s  = ((mode == MODE_SW) && run && !sat_q) || ((mode == MODE_TMR) && run && !f_zero_s);
  end

  // Candidate up-count and down-count values of the function counter.
  always_comb begin
    inc_h = f_h_q; inc_m = f_m_q; inc_s = f_s_q; inc_ss = f_ss_q;
    dec_h = f_h_q; dec_m = f_m_q; dec_s = f_s_q; dec_ss = f_ss_q;
    if (f_ss_q == SS_MAX) begin
      inc_ss = 7'd0;
      if (f_s_q == 6'd59) begin
        inc_s = 6'd0;
        if (f_m_q == 6'd59) begin
          inc_m = 6'd0;
          inc_h = f_h_q + 5'd1;
        end else begin
          inc_m = f_m_q + 6'd1;
        end
      end else begin
        inc_s = f_s_q + 6'd1;
      end
    end else begin
      inc_ss = f_ss_q + 7'd1;
    end
    if (f_ss_q != 7'd0) begin
      dec_ss = f_ss_q - 7'd1;
    end else begin
      dec_ss = SS_MAX;
      if (f_s_q != 6'd0) begin
        dec_s = f_s_q - 6'd1;
      end else begin
        dec_s = 6'd59;
        if (f_m_q != 6'd0) begin
          dec_m = f_m_q - 6'd1;
        end else begin
          dec_m = 6'd59;
          dec_h = f_h_q - 5'd1;
        end
      end
    end
    inc_max_s  = (inc_h == H_MAX) && (inc_m == 6'd59) && (inc_s == 6'd59) && (inc_ss == SS_MAX);
    dec_zero_s = (dec_h == 5'd0) && (dec_m == 6'd0) && (dec_s == 6'd0) && (dec_ss == 7'd0);
    done_s     = tm_cnt_s && dec_zero_s;
  end

  // Prescaler and free-running time-of-day counter.
  always_comb begin
    presc_d = presc_q + PW'(1);
    c_h_d = c_h_q; c_m_d = c_m_q; c_s_d = c_s_q; c_ss_d = c_ss_q;
    if (clk_ld_s) begin
      presc_d = '0;
      c_h_d = load_h; c_m_d = load_m; c_s_d = load_s; c_ss_d = 7'd0;
    end else if (sub_tick_s) begin
      presc_d = '0;
      if (c_ss_q == SS_MAX) begin
        c_ss_d = 7'd0;
        if (c_s_q == 6'd59) begin
          c_s_d = 6'd0;
          if (c_m_q == 6'd59) begin
            c_m_d = 6'd0;
            c_h_d = (c_h_q == H_MAX) ? 5'd0 : c_h_q + 5'd1;
          end else begin
            c_m_d = c_m_q + 6'd1;
          end
        end else begin
          c_s_d = c_s_q + 6'd1;
        end
      end else begin
        c_ss_d = c_ss_q + 7'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Function counter: clear, then timer load, then stopwatch/timer counting.
  always_comb begin
    f_h_d = f_h_q; f_m_d = f_m_q; f_s_d = f_s_q; f_ss_d = f_ss_q;
    sat_d = sat_q;
    if (clear) begin
      f_h_d = 5'd0; f_m_d = 6'd0; f_s_d = 6'd0; f_ss_d = 7'd0;
      sat_d = 1'b0;
    end else if (tmr_ld_s) begin
      f_h_d = load_h; f_m_d = load_m; f_s_d = load_s; f_ss_d = 7'd0;
    end else if (sw_cnt_s) begin
      if (f_max_s) begin
        sat_d = 1'b1;
      end else begin
        f_h_d = inc_h; f_m_d = inc_m; f_s_d = inc_s; f_ss_d = inc_ss;
        sat_d = inc_max_s;
      end
    end else if (tm_cnt_s) begin
      f_h_d = dec_h; f_m_d = dec_m; f_s_d = dec_s; f_ss_d = dec_ss;
    end else begin
      sat_d = sat_q;
    end
  end

  // Alarm holds for ALARM_S wall-clock seconds after expiry.
  always_comb begin
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (clear || clk_ld_s || tmr_ld_s) begin
      alarm_d = 1'b0;
      acnt_d  = '0;
    end else if (done_s) begin
      alarm_d = 1'b1;
      acnt_d  = '0;
    end else if (alarm_q && sec_tick_s) begin
      if (acnt_q == ALM_LAST) begin
        alarm_d = 1'b0;
        acnt_d  = '0;
      end else begin
        acnt_d = acnt_q + AW'(1);
      end
    end else begin
      acnt_d = acnt_q;
    end
  end

  // Display source selection.
  always_comb begin
    if (mode == MODE_CLK) begin
      disp_h_s = c_h_q; disp_m_s = c_m_q; disp_s_s = c_s_q; disp_ss_s = c_ss_q;
    end else begin
      disp_h_s = f_h_q; disp_m_s = f_m_q; disp_s_s = f_s_q; disp_ss_s = f_ss_q;
    end
  end

  // Counter and status state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      c_h_q <= 5'd0; c_m_q <= 6'd0; c_s_q <= 6'd0; c_ss_q <= 7'd0;
      f_h_q <= 5'd0; f_m_q <= 6'd0; f_s_q <= 6'd0; f_ss_q <= 7'd0;
      sat_q <= 1'b0; alarm_q <= 1'b0; acnt_q <= '0;
      tick_q <= 1'b0; hour_q <= 1'b0; done_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      c_h_q <= c_h_d; c_m_q <= c_m_d; c_s_q <= c_s_d; c_ss_q <= c_ss_d;
      f_h_q <= f_h_d; f_m_q <= f_m_d; f_s_q <= f_s_d; f_ss_q <= f_ss_d;
      sat_q <= sat_d; alarm_q <= alarm_d; acnt_q <= acnt_d;
      tick_q <= sec_tick_s; hour_q <= hour_s; done_q <= done_s;
    end
  end

  // Output registers; strobes are delayed to line up with the BCD they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_bcd <= 8'h00; m_bcd <= 8'h00; s_bcd <= 8'h00; ss_bcd <= 8'h00;
      tick_1s <= 1'b0; hour_pulse <= 1'b0; done <= 1'b0; alarm <= 1'b0;
      running <= 1'b0; sat <= 1'b0; load_err <= 1'b0;
    end else begin
      h_bcd      <= to_bcd({2'b00, disp_h_s});
      m_bcd      <= to_bcd({1'b0, disp_m_s});
      s_bcd      <= to_bcd({1'b0, disp_s_s});
      ss_bcd     <= to_bcd(disp_ss_s);
      tick_1s    <= tick_q;
      hour_pulse <= hour_q;
      done       <= done_q;
      alarm      <= alarm_q;
      running    <= running_s;
      sat        <= sat_q;
      load_err   <= ld_err_s;
    end
  end

endmodule
